id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard detection.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        alu_op,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [3:0]        ex_alu_op,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              hazard_stall,
  output logic [15:0]       bubble_count
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [15:0]       bubble_q, bubble_d;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // EX/MEM is the younger result, so it wins over MEM/WB; r0 never forwards.
  always_comb begin
    fwd_a = rs_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      fwd_a = memwb_result;
    end
    fwd_b = rt_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt)) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt)) begin
      fwd_b = memwb_result;
    end
  end

  assign hazard_stall = valid_q && mem_read_q && (rd_q != 5'd0) && in_valid &&
                        ((rd_q == rs) || (rd_q == rt));

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    bubble_d    = bubble_q;
    if (Stall) begin
      // hold everything
    end else if (Flush || hazard_stall) begin
      // Bubble: only the control bits are cleared, data fields are left as-is.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      if (!Flush && (bubble_q != 16'hFFFF)) begin
        bubble_d = bubble_q + 16'd1;
      end
    end else begin
      valid_d     = in_valid;
      reg_write_d = reg_write & in_valid;
      mem_read_d  = mem_read & in_valid;
      mem_write_d = mem_write & in_valid;
      alu_op_d    = alu_op;
      rd_d        = rd;
      a_d         = fwd_a;
      b_d         = fwd_b;
      imm_d       = imm;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      bubble_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      bubble_q    <= bubble_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_rd        = rd_q;
  assign ex_a         = a_q;
  assign ex_b         = b_q;
  assign ex_imm       = imm_q;
  assign bubble_count = bubble_q;

endmodule
